// File: rtl/bus_pkg.sv
// Shared encodings for the external memory bus arbiter.
// Owner IDs, FSM states and default limits.
package bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT
  } state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  localparam int DEF_STARVE_LIMIT = 4;
  localparam int DEF_TIMEOUT      = 255;

endpackage

// File: rtl/arb_pick.sv
// Fetch/data winner select with a saturating data-streak counter.
// Data wins ties until the streak reaches STARVE_LIMIT.
module arb_pick
  import bus_pkg::*;
#(
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic   clk,
  input  logic   nrst,
  input  logic   i_req,
  input  logic   d_req,
  input  logic   gnt,
  output owner_e owner
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [SW-1:0] streak_q, streak_d;
  logic          starved;

  assign starved = (streak_q == SW'(STARVE_LIMIT));

  always_comb begin
    owner = OWN_I;
    unique case (1'b1)
      (d_req && !(i_req && starved)): owner = OWN_D;
      default:                        owner = OWN_I;
    endcase
  end

  always_comb begin
    streak_d = streak_q;
    if (gnt) begin
      if (owner == OWN_D && i_req) begin
        streak_d = starved ? streak_q : streak_q + SW'(1);
      end else begin
        streak_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      streak_q <= '0;
    end else begin
      streak_q <= streak_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory bus shared by fetch and data paths.
// One transaction in flight; responses routed back to the owner.
module mem_arbiter
  import bus_pkg::*;
#(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT,
  parameter int TIMEOUT      = DEF_TIMEOUT
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic            i_req,
  input  logic [AW-1:0]   i_addr,
  output logic            i_gnt,
  output logic            i_rvalid,
  output logic [DW-1:0]   i_rdata,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [DW/8-1:0] d_be,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  output logic            d_gnt,
  output logic            d_rvalid,
  output logic [DW-1:0]   d_rdata,
  output logic            m_req,
  output logic            m_we,
  output logic [DW/8-1:0] m_be,
  output logic [AW-1:0]   m_addr,
  output logic [DW-1:0]   m_wdata,
  input  logic            m_ready,
  input  logic            m_rvalid,
  input  logic [DW-1:0]   m_rdata,
  output logic            err
);

  localparam int BW = DW / 8;
  localparam int TW = $clog2(TIMEOUT + 1);

  state_e          state_q, state_d;
  owner_e          owner_q, owner_d, pick;
  logic [TW-1:0]   timer_q, timer_d;
  logic            wr_q, wr_d;
  logic            grant;
  logic            i_gnt_q, i_gnt_d, d_gnt_q, d_gnt_d;
  logic            i_rv_q, i_rv_d, d_rv_q, d_rv_d;
  logic [DW-1:0]   i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
  logic            err_q, err_d;
  logic            m_req_q, m_req_d, m_we_q, m_we_d;
  logic [BW-1:0]   m_be_q, m_be_d;
  logic [AW-1:0]   m_addr_q, m_addr_d;
  logic [DW-1:0]   m_wdata_q, m_wdata_d;
  logic            resp, tmo;
  logic [DW-1:0]   rdata;

  arb_pick #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_pick (
    .clk  (clk),
    .nrst (nrst),
    .i_req(i_req),
    .d_req(d_req),
    .gnt  (grant),
    .owner(pick)
  );

  // A late m_rvalid beats the timeout; writes return zero data.
  assign resp  = m_rvalid;
  assign tmo   = !m_rvalid && (timer_q == TW'(TIMEOUT - 1));
  assign rdata = (resp && !wr_q) ? m_rdata : '0;

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    timer_d   = timer_q;
    wr_d      = wr_q;
    grant     = 1'b0;
    i_gnt_d   = 1'b0;
    d_gnt_d   = 1'b0;
    i_rv_d    = 1'b0;
    d_rv_d    = 1'b0;
    i_rdata_d = '0;
    d_rdata_d = '0;
    err_d     = 1'b0;
    m_req_d   = m_req_q;
    m_we_d    = m_we_q;
    m_be_d    = m_be_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    unique case (state_q)
      ST_IDLE: begin
        if (i_req || d_req) begin
          grant   = 1'b1;
          owner_d = pick;
          m_req_d = 1'b1;
          state_d = ST_ISSUE;
          if (pick == OWN_D) begin
            d_gnt_d   = 1'b1;
            wr_d      = d_we;
            m_we_d    = d_we;
            m_be_d    = d_be;
            m_addr_d  = d_addr;
            m_wdata_d = d_we ? d_wdata : '0;
          end else begin
            i_gnt_d   = 1'b1;
            wr_d      = 1'b0;
            m_we_d    = 1'b0;
            m_be_d    = '1;
            m_addr_d  = i_addr;
            m_wdata_d = '0;
          end
        end
      end
      ST_ISSUE: begin
        if (m_ready) begin
          m_req_d   = 1'b0;
          m_we_d    = 1'b0;
          m_be_d    = '0;
          m_addr_d  = '0;
          m_wdata_d = '0;
          timer_d   = '0;
          state_d   = ST_WAIT;
        end
      end
      ST_WAIT: begin
        timer_d = timer_q + TW'(1);
        if (resp || tmo) begin
          err_d   = tmo;
          state_d = ST_IDLE;
          if (owner_q == OWN_D) begin
            d_rv_d    = 1'b1;
            d_rdata_d = rdata;
          end else begin
            i_rv_d    = 1'b1;
            i_rdata_d = rdata;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q   <= ST_IDLE;
      owner_q   <= OWN_I;
      timer_q   <= '0;
      wr_q      <= 1'b0;
      i_gnt_q   <= 1'b0;
      d_gnt_q   <= 1'b0;
      i_rv_q    <= 1'b0;
      d_rv_q    <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      err_q     <= 1'b0;
      m_req_q   <= 1'b0;
      m_we_q    <= 1'b0;
      m_be_q    <= '0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      timer_q   <= timer_d;
      wr_q      <= wr_d;
      i_gnt_q   <= i_gnt_d;
      d_gnt_q   <= d_gnt_d;
      i_rv_q    <= i_rv_d;
      d_rv_q    <= d_rv_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      err_q     <= err_d;
      m_req_q   <= m_req_d;
      m_we_q    <= m_we_d;
      m_be_q    <= m_be_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
    end
  end

  assign i_gnt    = i_gnt_q;
  assign d_gnt    = d_gnt_q;
  assign i_rvalid = i_rv_q;
  assign d_rvalid = d_rv_q;
  assign i_rdata  = i_rdata_q;
  assign d_rdata  = d_rdata_q;
  assign err      = err_q;
  assign m_req    = m_req_q;
  assign m_we     = m_we_q;
  assign m_be     = m_be_q;
  assign m_addr   = m_addr_q;
  assign m_wdata  = m_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: vector table, corner sequences, random traffic.
// Expected owner comes from a streak model of the arbitration rules.
`define CHK(n, a, e) chk(n, 160'(a), 160'(e))

module tb_mem_arbiter;

  localparam int TIMEOUT = 8;
  localparam int LIMIT   = 4;

  logic        clk = 1'b0;
  logic        nrst;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_gnt, i_rvalid;
  logic [31:0] i_rdata;
  logic        d_req, d_we;
  logic [3:0]  d_be;
  logic [31:0] d_addr, d_wdata;
  logic        d_gnt, d_rvalid;
  logic [31:0] d_rdata;
  logic        m_req, m_we;
  logic [3:0]  m_be;
  logic [31:0] m_addr, m_wdata;
  logic        m_ready, m_rvalid;
  logic [31:0] m_rdata;
  logic        err;

  int n_vec = 0;
  int n_err = 0;
  int streak_m = 0;

  mem_arbiter #(
    .AW(32), .DW(32), .STARVE_LIMIT(LIMIT), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .nrst(nrst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt),
    .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid),
    .d_rdata(d_rdata),
    .m_req(m_req), .m_we(m_we), .m_be(m_be), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_ready(m_ready), .m_rvalid(m_rvalid),
    .m_rdata(m_rdata), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          ir, dr, we;
    logic [3:0]  be;
    logic [31:0] ia, da, wd, rd;
    int          rdy, rv;
    bit          exp_d;
    logic [31:0] exp_rdata;
    bit          exp_err;
  } vec_t;

  vec_t tbl[8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [159:0] act,
                     input logic [159:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    nrst = 1'b0;
    i_req = 1'b0; d_req = 1'b0; m_ready = 1'b0; m_rvalid = 1'b0;
    tick();
    tick();
    `CHK("reset_outs",
         {i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
          m_req, m_we, m_be, m_addr, m_wdata, err}, 0);
    nrst = 1'b1;
    streak_m = 0;
  endtask

  function automatic bit model_pick(input bit ir, input bit dr);
    bit d;
    d = (ir && dr) ? (streak_m != LIMIT) : dr;
    if (d && ir) streak_m = (streak_m < LIMIT) ? streak_m + 1 : LIMIT;
    else streak_m = 0;
    return d;
  endfunction

  task automatic run_txn(input bit exp_d, input int rdy, input int rv,
                         input logic [31:0] rd,
                         input logic [31:0] exp_rdata, input bit exp_err);
    logic        ewe;
    logic [3:0]  eb;
    logic [31:0] ea, ew;
    int          done_c;
    ewe = exp_d ? d_we : 1'b0;
    eb  = exp_d ? d_be : 4'hF;
    ea  = exp_d ? d_addr : i_addr;
    ew  = (exp_d && d_we) ? d_wdata : 32'h0;
    tick();
    `CHK("gnt", {i_gnt, d_gnt}, (exp_d ? 2'b01 : 2'b10));
    `CHK("m_issue", {m_req, m_we, m_be, m_addr, m_wdata},
         {1'b1, ewe, eb, ea, ew});
    if (exp_d) d_req = 1'b0;
    else i_req = 1'b0;
    for (int k = 0; k < rdy; k++) begin
      tick();
      `CHK("stall", {m_req, m_addr, i_gnt, d_gnt}, {1'b1, ea, 2'b00});
    end
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    `CHK("m_wait", {m_req, m_we, m_be, m_addr, m_wdata}, 0);
    done_c = -1;
    for (int c = 0; c < TIMEOUT && done_c < 0; c++) begin
      m_rvalid = (c == rv);
      m_rdata  = rd;
      tick();
      m_rvalid = 1'b0;
      if (i_rvalid || d_rvalid || err) done_c = c;
    end
    `CHK("resp_cycle", done_c, (exp_err ? TIMEOUT - 1 : rv));
    `CHK("rvalid", {i_rvalid, d_rvalid, err}, {!exp_d, exp_d, exp_err});
    `CHK("rdata", (exp_d ? d_rdata : i_rdata), exp_rdata);
    `CHK("other_rdata", (exp_d ? i_rdata : d_rdata), 0);
  endtask

  initial begin
    i_addr = '0; d_we = 1'b0; d_be = '0; d_addr = '0; d_wdata = '0;
    m_rdata = '0;

    tbl[0] = '{1'b1, 1'b0, 1'b0, 4'h0, 32'h100, 32'h0, 32'h0,
               32'h00500093, 0, 0, 1'b0, 32'h00500093, 1'b0};
    tbl[1] = '{1'b1, 1'b1, 1'b1, 4'h3, 32'h104, 32'h2000, 32'hDEADBEEF,
               32'h12345678, 0, 0, 1'b1, 32'h0, 1'b0};
    tbl[2] = '{1'b1, 1'b0, 1'b0, 4'h0, 32'h104, 32'h0, 32'h0,
               32'h00100113, 0, 1, 1'b0, 32'h00100113, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 1'b0, 4'h0, 32'h0, 32'h40, 32'h0,
               32'hCAFEF00D, 5, 3, 1'b1, 32'hCAFEF00D, 1'b0};
    tbl[4] = '{1'b0, 1'b1, 1'b0, 4'h0, 32'h0, 32'h44, 32'h0,
               32'h11111111, 1, 99, 1'b1, 32'h0, 1'b1};
    tbl[5] = '{1'b1, 1'b0, 1'b0, 4'h0, 32'h200, 32'h0, 32'h0,
               32'h22222222, 0, 7, 1'b0, 32'h22222222, 1'b0};
    tbl[6] = '{1'b0, 1'b1, 1'b1, 4'hF, 32'h0, 32'h48, 32'hA5A5A5A5,
               32'h33333333, 2, 2, 1'b1, 32'h0, 1'b0};
    tbl[7] = '{1'b1, 1'b0, 1'b0, 4'h0, 32'h204, 32'h0, 32'h0,
               32'h44444444, 0, 8, 1'b0, 32'h0, 1'b1};

    do_reset();
    foreach (tbl[i]) begin
      i_req = tbl[i].ir; d_req = tbl[i].dr; d_we = tbl[i].we;
      d_be = tbl[i].be; i_addr = tbl[i].ia; d_addr = tbl[i].da;
      d_wdata = tbl[i].wd;
      run_txn(tbl[i].exp_d, tbl[i].rdy, tbl[i].rv, tbl[i].rd,
              tbl[i].exp_rdata, tbl[i].exp_err);
    end

    do_reset();
    i_req = 1'b1; i_addr = 32'h300;
    for (int g = 0; g < LIMIT + 1; g++) begin
      d_req = 1'b1; d_we = 1'b0; d_be = 4'h0; d_addr = 32'h1000 + g;
      run_txn(g < LIMIT, 0, 0, 32'h5000 + g,
              (g < LIMIT) ? 32'h5000 + g : 32'h5000 + g, 1'b0);
    end
    i_req = 1'b1; i_addr = 32'h304;
    d_req = 1'b1; d_addr = 32'h1100;
    run_txn(1'b1, 0, 0, 32'h77, 32'h77, 1'b0);
    i_req = 1'b1;
    run_txn(1'b0, 0, 0, 32'h88, 32'h88, 1'b0);

    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h60;
    tick();
    d_req = 1'b0; m_ready = 1'b1;
    tick();
    m_ready = 1'b0; nrst = 1'b0;
    tick();
    `CHK("rst_wait_outs",
         {i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
          m_req, m_we, m_be, m_addr, m_wdata, err}, 0);
    n_vec++;
    if ({m_req, m_addr, d_rvalid, d_rdata} !== '0) begin
      n_err++;
      $display("FAIL rst_wait_bus: m_req=%b m_addr=%0h", m_req, m_addr);
    end
    nrst = 1'b1; streak_m = 0;
    m_rvalid = 1'b1; m_rdata = 32'hBAD0BAD0;
    tick();
    m_rvalid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      `CHK("stray_resp", {i_rvalid, d_rvalid, err, m_req}, 0);
      n_vec++;
      if ({i_rvalid, d_rvalid, err, m_req, i_rdata, d_rdata} !== '0) begin
        n_err++;
        $display("FAIL stray_inline: rv=%b%b err=%b", i_rvalid,
                 d_rvalid, err);
      end
    end

    i_req = 1'b0; d_req = 1'b0;
    for (int t = 0; t < 40; t++) begin
      bit          ed, ee;
      int          rdy, rv;
      logic [31:0] rd, er;
      if (!i_req) begin
        i_req = 1'($urandom_range(0, 1));
        i_addr = $urandom & 32'hFFFF_FFFC;
      end
      if (!d_req) begin
        d_req = 1'($urandom_range(0, 1));
        d_we = 1'($urandom_range(0, 1));
        d_be = 4'($urandom);
        d_addr = $urandom;
        d_wdata = $urandom;
      end
      if (!i_req && !d_req) d_req = 1'b1;
      ed  = model_pick(i_req, d_req);
      rdy = int'($urandom_range(0, 3));
      rv  = int'($urandom_range(0, 9));
      rd  = $urandom;
      ee  = (rv >= TIMEOUT);
      er  = (ee || (ed && d_we)) ? 32'h0 : rd;
      run_txn(ed, rdy, rv, rd, er, ee);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares one external single-port memory bus between the core's instruction-fetch path (ins_mod external-fetch side) and its data-memory path (dmem_mod).
Arbitrates, issues one transaction at a time, routes the response back to the owner, and bounds wait time with a timeout.
Data side has priority, since it carries the older instruction in stage 3. Instruction fetch is protected from starvation by a streak limit.

Parameters:
AW, 32, address width
DW, 32, data width (byte enables are DW/8)
STARVE_LIMIT, 4, max consecutive data grants while i_req pending (>=1)
TIMEOUT, 255, max cycles waiting for m_rvalid before abort (>=1)

Ports:
clk  in  1  clock, all logic on rising edge
nrst  in  1  reset, synchronous, active-low
i_req  in  1  fetch request; held with i_addr until i_gnt
i_addr  in  AW  fetch address
i_gnt  out  1  one-cycle pulse: fetch request captured
i_rvalid  out  1  one-cycle pulse: i_rdata valid
i_rdata  out  DW  fetch data
d_req  in  1  data request; held with d_we/d_be/d_addr/d_wdata until d_gnt
d_we  in  1  1=write, 0=read
d_be  in  DW/8  byte enables (writes)
d_addr  in  AW  data address
d_wdata  in  DW  write data
d_gnt  out  1  one-cycle pulse: data request captured
d_rvalid  out  1  one-cycle pulse: read data / write ack
d_rdata  out  DW  read data (0 for writes)
m_req  out  1  bus request, held until m_ready
m_we  out  1  bus write
m_be  out  DW/8  bus byte enables (all ones for fetch)
m_addr  out  AW  bus address
m_wdata  out  DW  bus write data
m_ready  in  1  bus accepts request this cycle (m_req&&m_ready)
m_rvalid  in  1  response valid, also acks writes
m_rdata  in  DW  response data
err  out  1  one-cycle pulse on timeout

Behaviour:
- Reset (nrst=0 at clk edge): state=IDLE, streak=0, timer=0, owner=0. All outputs 0, including m_* and rdata.
- Reset mid-transaction: abandons the transaction. No rvalid is issued. Any m_rvalid arriving later in IDLE is ignored.
- FSM states and transitions:
  - IDLE, any request present at edge: winner chosen, request fields registered into m_*, gnt pulse, move to ISSUE.
  - ISSUE: m_req=1, fields stable. On m_req&&m_ready: m_req drops next cycle, timer=0, move to WAIT.
  - WAIT: timer increments each cycle.
    - On m_rvalid: owner's rvalid=1 and rdata=m_rdata (registered, 1 cycle after m_rvalid; d_rdata=0 for writes). Move to IDLE.
    - On timer==TIMEOUT-1 without m_rvalid: err=1, owner rvalid=1, rdata=0. Move to IDLE.
    - m_rvalid and timeout in the same cycle: m_rvalid wins, no err.
- Minimum latency: req seen at cycle N; gnt+m_req at N+1; with m_ready=1, WAIT at N+2; with m_rvalid at N+2, rvalid at N+3.
- Back-to-back: after rvalid the FSM is in IDLE and arbitrates that same cycle. Throughput is therefore 1 transaction per 3 cycles minimum.
- Requesters may drop req the cycle after gnt. A req still high while in ISSUE/WAIT is ignored.
- Arbitration (in IDLE only):
  - only i_req → instr
  - only d_req → data
  - both → data, unless streak==STARVE_LIMIT, then instr.
- Streak counter:
  - increments on a data grant while i_req=1
  - clears on any instr grant
  - clears on a data grant with i_req=0
  - saturates at STARVE_LIMIT
- m_be for fetch = all ones, m_we=0. m_wdata=0 for reads.
- m_* change only on entry to ISSUE. They return to 0 in WAIT/IDLE.

Decomposition:
- Shared bus_pkg (include/header): state encodings IDLE/ISSUE/WAIT, owner IDs OWN_I=0/OWN_D=1, default STARVE_LIMIT/TIMEOUT.
- One sub-module, arb_pick: winner select plus the saturating streak counter (inputs i_req, d_req, grant strobe; output owner).
- FSM, timer and muxing stay in mem_arbiter.

Test Plan:
- Single fetch: i_req=1, i_addr=0x100, m_ready=1, m_rvalid with m_rdata=0x00500093 two cycles later → i_gnt at N+1; m_addr=0x100, m_be=0xF; i_rvalid with i_rdata=0x00500093 at N+3; d_rvalid=0.
- Simultaneous: i_req and d_req (write 0xDEADBEEF @0x2000, be=0x3) → data granted first, m_we=1, m_be=0x3; fetch granted on next IDLE; d_rdata=0.
- Starvation: d_req held high continuously, i_req high, STARVE_LIMIT=4 → 4 data grants, then i_gnt on the 5th grant; streak=0 after.
- m_ready backpressure: m_ready low for 5 cycles → m_req and m_addr stable for all 5 cycles; single acceptance; no duplicate gnt.
- Timeout: TIMEOUT=8, no m_rvalid → err pulse and d_rvalid with d_rdata=0 exactly 8 cycles after acceptance; FSM returns to IDLE and accepts a new request.
- Reset in WAIT: nrst=0 for 1 cycle, then stray m_rvalid → all outputs 0 after the edge; no i_rvalid/d_rvalid from the stray response.
